// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     - state_e   : FSM state encoding (IDLE / SHIFT / DONE)
//     - cnt_width : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The counter only needs to reach WIDTH-1. The guard keeps a 1-bit
    // counter for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// ---------------------------------------------------------------------------
// full_subtractor_cell
//   One-bit full subtractor: computes a - b - bin.
//   Ports:
//     a, b  : operand bits
//     bin   : borrow in
//     d     : difference bit
//     bout  : borrow out (1 when a < b + bin)
// ---------------------------------------------------------------------------
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;
    // Borrow when a=0,b=1, or when the bits are equal and a borrow arrives.
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing A - B - Bin, LSB first, one bit
//   per clock through a single full_subtractor_cell and a registered borrow.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow
//   output ovf. Without it the port and its logic are absent.
//
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     start_valid/ready : operation request handshake (a_in, b_in, bin)
//     a_in, b_in, bin   : operands, sampled only on the start handshake
//     done_valid/ready  : result handshake
//     diff_out, bout    : result and final borrow, 0 outside DONE
//     ovf               : signed overflow (SERIAL_SUB_OVF_EN only)
//     busy              : high in SHIFT or DONE
//     state_dbg         : current FSM state, for observation only
//
//   Handshake rule (both interfaces): a transfer happens on a rising edge
//   where valid and ready are both high. ready never depends on valid in the
//   same cycle, and every output here comes straight from a register or a
//   decode of the state register.
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    borrow_d = bin;
                    cnt_d    = '0;
                    diff_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                diff_d   = {cell_d, diff_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit the register LSBs hold the operand MSBs.
                    ovf_d = (a_q[0] != b_q[0]) & (cell_d != a_q[0]);
`endif
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Results are gated by the state register so partial shift contents and
    // the in-flight borrow are never visible.
    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q == SHIFT) || (state_q == DONE);
    assign diff_out    = done_valid ? diff_q : '0;
    assign bout        = done_valid & borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf         = done_valid & ovf_q;
`endif
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
//   from integer arithmetic on the operands and flow through a scoreboard
//   queue. Optional ovf checks are compiled in with SERIAL_SUB_OVF_EN.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] diff_out;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif
    logic             busy;
    logic [1:0]       state_dbg;

    int n_cmp;
    int n_err;

    // Scoreboard entry: {ovf, bout, diff}
    logic [WIDTH+1:0] exp_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .bin         (bin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff_out    (diff_out),
        .bout        (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf),
`endif
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer subtraction.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic bi);
        int r;
        int sr;
        logic [WIDTH-1:0] d;
        logic bo;
        logic ov;
        r  = int'(a) - int'(b) - int'(bi);
        d  = WIDTH'(r);
        bo = (r < 0);
        sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ov = (sr > 127) || (sr < -128);
        return {ov, bo, d};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_diff_out"}, 32'(diff_out), 32'd0);
        check({tag, "_bout"}, 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
    endtask

    task automatic check_result(input string tag, input logic [WIDTH+1:0] e);
        check({tag, "_diff"}, 32'(diff_out), 32'(e[WIDTH-1:0]));
        check({tag, "_bout"}, 32'(bout), 32'(e[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
`endif
    endtask

    // ---------------- driver ----------------
    // Starts one operation and waits for done_valid; returns at #1 after the
    // edge on which done_valid rose (or after the timeout).
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bi, output bit ok);
        int n;
        @(negedge clk);
        check("pre_start_ready", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        bin  = bi;
        exp_q.push_back(model(a, b, bi));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
        bin  = 1'($urandom);
        n = 0;
        while (!done_valid && n < TIMEOUT) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("latency", 32'(n), 32'(WIDTH));
        ok = done_valid;
    endtask

    // Holds the result for 'stall' cycles (poking start_valid meanwhile when
    // 'poke' is set), then completes the done handshake.
    task automatic finish_op(input string tag, input int stall, input bit poke);
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        check_result(tag, e);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (poke) begin
                start_valid = 1'($urandom_range(0, 1));
                a_in = WIDTH'($urandom);
                b_in = WIDTH'($urandom);
                bin  = 1'($urandom);
            end
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            if (poke) begin
                check({tag, "_hold_start_ready"}, 32'(start_ready), 32'd0);
                check({tag, "_hold_done_valid"}, 32'(done_valid), 32'd1);
                check_result({tag, "_hold"}, e);
            end
        end
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check_idle_outputs({tag, "_after_done"});
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic bi,
                          input int stall, input bit poke);
        bit ok;
        start_op(a, b, bi, ok);
        if (ok) begin
            finish_op(tag, stall, poke);
        end else begin
            void'(exp_q.pop_front());
            // Recover the DUT for subsequent operations.
            rst_n = 1'b0;
            #3;
            rst_n = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("sub_5_3", 8'h05, 8'h03, 1'b0, 0, 1'b0);
        run_op("sub_3_5", 8'h03, 8'h05, 1'b0, 0, 1'b0);
        run_op("sub_0_0_b", 8'h00, 8'h00, 1'b1, 0, 1'b0);
        run_op("sub_80_1", 8'h80, 8'h01, 1'b0, 0, 1'b0);
        run_op("sub_7f_1", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op("sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 1, 1'b0);

        // Backpressure with ignored start requests
        run_op("bp", 8'h5A, 8'hC3, 1'b1, 5, 1'b1);

        // Reset during the 4th SHIFT cycle
        start_op(8'h12, 8'h34, 1'b0, ok);
        void'(exp_q.pop_front());
        if (ok) begin
            // Synchronise for the discarded op, then reset mid-SHIFT below.
            finish_op_discard();
        end
        @(negedge clk);
        start_valid = 1'b1;
        a_in = 8'hC0;
        b_in = 8'h0F;
        bin = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_aa_55", 8'hAA, 8'h55, 1'b0, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Clears a completed op without model checks (its expectation was dropped).
    task automatic finish_op_discard();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

endmodule
